// File: rtl/sketch_pkg.sv
// Shared constants, FSM encoding and saturating-increment helper for the
// count-min sketch counter update block.
package sketch_pkg;

    localparam int CNT_W  = 16;
    localparam int DEPTH1 = 2140;
    localparam int DEPTH2 = 1070;
    localparam int DEPTH3 = 535;
    localparam int AW1    = 12;
    localparam int AW2    = 11;
    localparam int AW3    = 10;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Counters up to 32 bits wide; caller passes its all-ones value as max_v.
    function automatic logic [31:0] sat_inc(input logic [31:0] old, input logic [31:0] max_v);
        logic [31:0] res;
        if (old == max_v) begin
            res = old;
        end else begin
            res = old + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sketch_row_rmw.sv
// One sketch row: counter RAM with a read / increment / write pipeline,
// two-deep write forwarding and the zero-fill port used by the init sweep.
module sketch_row_rmw
    import sketch_pkg::*;
#(
    parameter int P_DEPTH = DEPTH1,
    parameter int P_AW    = AW1,
    parameter int P_W     = CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              upd_i,
    input  logic [P_AW-1:0]   addr_i,
    input  logic              init_we_i,
    input  logic [P_AW-1:0]   init_addr_i,
    output logic [P_W-1:0]    new_o,
    output logic              sat_o,
    output logic              vld_o
);

    localparam logic [P_W-1:0] MAX_V = '1;

    logic [P_W-1:0]  mem_q [P_DEPTH];
    logic [P_W-1:0]  rd_q;
    logic [P_AW-1:0] a0_q, a1_q, a2_q;
    logic            v0_q, v1_q, v2_q;
    logic [P_W-1:0]  n1_q, n2_q;
    logic            s1_q;
    logic [P_W-1:0]  old_d, new_d;
    logic            sat_d;
    logic [31:0]     inc_d;

    // Stage 1 is being written this edge and stage 2 was written on the same
    // edge our read was issued, so neither is visible in rd_q; newest wins.
    always_comb begin
        old_d = rd_q;
        if (v1_q && (a1_q == a0_q)) begin
            old_d = n1_q;
        end else if (v2_q && (a2_q == a0_q)) begin
            old_d = n2_q;
        end else begin
            old_d = rd_q;
        end
        sat_d = (old_d == MAX_V);
        inc_d = sat_inc(32'(old_d), 32'(MAX_V));
        new_d = inc_d[P_W-1:0];
    end

    // Pipeline stage registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v0_q <= upd_i;
            v1_q <= v0_q;
            v2_q <= v1_q;
        end
        a0_q <= addr_i;
        a1_q <= a0_q;
        a2_q <= a1_q;
        n1_q <= new_d;
        n2_q <= n1_q;
        s1_q <= sat_d;
    end

    // Counter RAM: one synchronous read port, one write port.
    always_ff @(posedge clk_i) begin
        if (upd_i) begin
            rd_q <= mem_q[addr_i];
        end
        if (rst_n_i && init_we_i) begin
            mem_q[init_addr_i] <= '0;
        end else if (rst_n_i && v1_q) begin
            mem_q[a1_q] <= n1_q;
        end
    end

    assign new_o = n1_q;
    assign sat_o = s1_q;
    assign vld_o = v1_q;

endmodule

// File: rtl/sketch_counter_update.sv
// Count-min sketch update: init sweep FSM, input qualification and the
// min / saturation reduction over the three row pipelines.
module sketch_counter_update
    import sketch_pkg::*;
#(
    parameter int CW = CNT_W
) (
    input  logic            sys_clk,
    input  logic            rst_n,
    input  logic [AW1-1:0]  Hash_add1,
    input  logic [AW2-1:0]  Hash_add2,
    input  logic [AW3-1:0]  Hash_add3,
    input  logic            Hash_valid,
    output logic            Ready,
    output logic [CW-1:0]   Est,
    output logic            Est_valid,
    output logic            Sat_flag,
    output logic            Drop
);

    state_e         state_q;
    logic [AW1-1:0] sweep_q;
    logic           ready_q;
    logic [CW-1:0]  est_q;
    logic           est_valid_q, sat_q, drop_q;

    logic           accept_s, init_s;
    logic           init_we2_s, init_we3_s;
    logic [CW-1:0]  n1_s, n2_s, n3_s, min12_s, min_s;
    logic           s1_s, s2_s, s3_s, v1_s, v2_s, v3_s, v_s;

    // Init sweep FSM; Ready rises on the edge that clears the last row-1 entry.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (sweep_q == AW1'(DEPTH1 - 1)) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        sweep_q <= sweep_q + 12'd1;
                    end
                end
                ST_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_INIT;
                    sweep_q <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        init_s     = (state_q == ST_INIT);
        init_we2_s = init_s && (sweep_q < AW1'(DEPTH2));
        init_we3_s = init_s && (sweep_q < AW1'(DEPTH3));
        accept_s   = Hash_valid && ready_q &&
                     (Hash_add1 < AW1'(DEPTH1)) &&
                     (Hash_add2 < AW2'(DEPTH2)) &&
                     (Hash_add3 < AW3'(DEPTH3));
    end

    sketch_row_rmw #(.P_DEPTH(DEPTH1), .P_AW(AW1), .P_W(CW)) u_row1 (
        .clk_i(sys_clk), .rst_n_i(rst_n), .upd_i(accept_s), .addr_i(Hash_add1),
        .init_we_i(init_s), .init_addr_i(sweep_q),
        .new_o(n1_s), .sat_o(s1_s), .vld_o(v1_s)
    );

    sketch_row_rmw #(.P_DEPTH(DEPTH2), .P_AW(AW2), .P_W(CW)) u_row2 (
        .clk_i(sys_clk), .rst_n_i(rst_n), .upd_i(accept_s), .addr_i(Hash_add2),
        .init_we_i(init_we2_s), .init_addr_i(sweep_q[AW2-1:0]),
        .new_o(n2_s), .sat_o(s2_s), .vld_o(v2_s)
    );

    sketch_row_rmw #(.P_DEPTH(DEPTH3), .P_AW(AW3), .P_W(CW)) u_row3 (
        .clk_i(sys_clk), .rst_n_i(rst_n), .upd_i(accept_s), .addr_i(Hash_add3),
        .init_we_i(init_we3_s), .init_addr_i(sweep_q[AW3-1:0]),
        .new_o(n3_s), .sat_o(s3_s), .vld_o(v3_s)
    );

    always_comb begin
        v_s     = v1_s & v2_s & v3_s;
        min12_s = (n1_s < n2_s) ? n1_s : n2_s;
        min_s   = (min12_s < n3_s) ? min12_s : n3_s;
    end

    // Registered outputs; Est holds its last value between updates.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            est_q       <= '0;
            est_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            est_valid_q <= v_s;
            sat_q       <= v_s & (s1_s | s2_s | s3_s);
            drop_q      <= Hash_valid & ~accept_s;
            if (v_s) begin
                est_q <= min_s;
            end else begin
                est_q <= est_q;
            end
        end
    end

    assign Ready     = ready_q;
    assign Est       = est_q;
    assign Est_valid = est_valid_q;
    assign Sat_flag  = sat_q;
    assign Drop      = drop_q;

endmodule

// File: tb/tb_sketch_counter_update.sv
// Directed bench: scoreboard of expected estimates from a shadow counter model,
// one default-width DUT and one 4-bit DUT for saturation.
module tb_sketch_counter_update;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [11:0] h1 = 12'd0, s_h1 = 12'd0;
    logic [10:0] h2 = 11'd0, s_h2 = 11'd0;
    logic [9:0]  h3 = 10'd0, s_h3 = 10'd0;
    logic        hv = 1'b0, s_hv = 1'b0;

    logic        ready, ev, sat, drop;
    logic [15:0] est;
    logic        s_ready, s_ev, s_sat, s_drop;
    logic [3:0]  s_est;

    typedef struct {
        int est;
        bit sat;
        int due;
    } exp_t;

    exp_t q16[$];
    exp_t q4[$];
    exp_t e16, e4;
    int   m1[int];
    int   m2[int];
    int   m3[int];
    int   cnt4 = 0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    sketch_counter_update u_dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .Hash_add1(h1), .Hash_add2(h2), .Hash_add3(h3), .Hash_valid(hv),
        .Ready(ready), .Est(est), .Est_valid(ev), .Sat_flag(sat), .Drop(drop)
    );

    sketch_counter_update #(.CW(4)) u_sat (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .Hash_add1(s_h1), .Hash_add2(s_h2), .Hash_add3(s_h3), .Hash_valid(s_hv),
        .Ready(s_ready), .Est(s_est), .Est_valid(s_ev), .Sat_flag(s_sat), .Drop(s_drop)
    );

    always #4 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Scoreboard monitors, sampled on the falling edge.
    always @(negedge sys_clk) begin
        if (ev) begin
            if (q16.size() == 0) begin
                check("unexpected_est_valid", 1, 0);
            end else begin
                e16 = q16.pop_front();
                check("est", int'(est), e16.est);
                check("sat_flag", int'(sat), int'(e16.sat));
                check("est_latency", cyc, e16.due);
            end
        end else begin
            check("sat_idle", int'(sat), 0);
        end
        if (s_ev) begin
            if (q4.size() == 0) begin
                check("unexpected_est_valid_w4", 1, 0);
            end else begin
                e4 = q4.pop_front();
                check("est_w4", int'(s_est), e4.est);
                check("sat_flag_w4", int'(s_sat), int'(e4.sat));
                check("est_latency_w4", cyc, e4.due);
            end
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic upd(input int a1, input int a2, input int a3);
        int o1, o2, o3, n1, n2, n3, mn;
        exp_t e;
        o1 = m1.exists(a1) ? m1[a1] : 0;
        o2 = m2.exists(a2) ? m2[a2] : 0;
        o3 = m3.exists(a3) ? m3[a3] : 0;
        n1 = (o1 == 65535) ? o1 : o1 + 1;
        n2 = (o2 == 65535) ? o2 : o2 + 1;
        n3 = (o3 == 65535) ? o3 : o3 + 1;
        m1[a1] = n1;
        m2[a2] = n2;
        m3[a3] = n3;
        mn = (n1 < n2) ? n1 : n2;
        mn = (mn < n3) ? mn : n3;
        e.est = mn;
        e.sat = (o1 == 65535) || (o2 == 65535) || (o3 == 65535);
        e.due = cyc + 3;
        q16.push_back(e);
        h1 = 12'(a1); h2 = 11'(a2); h3 = 10'(a3); hv = 1'b1;
        step();
        hv = 1'b0;
    endtask

    task automatic upd_raw(input int a1, input int a2, input int a3);
        h1 = 12'(a1); h2 = 11'(a2); h3 = 10'(a3); hv = 1'b1;
        step();
        hv = 1'b0;
    endtask

    task automatic upd4();
        exp_t e;
        e.sat = (cnt4 == 15);
        cnt4  = (cnt4 == 15) ? 15 : cnt4 + 1;
        e.est = cnt4;
        e.due = cyc + 3;
        q4.push_back(e);
        s_h1 = 12'd3; s_h2 = 11'd3; s_h3 = 10'd3; s_hv = 1'b1;
        step();
        s_hv = 1'b0;
    endtask

    task automatic wait_init(input int hv_at);
        for (int c = 1; c <= 2140; c++) begin
            step();
            check("ready_sweep", int'(ready), (c >= 2140) ? 1 : 0);
            if (c == hv_at) begin
                check("drop_during_init", int'(drop), 1);
            end
            if (c == hv_at + 1) begin
                check("drop_clear", int'(drop), 0);
            end
            hv = 1'b0;
            if (c == hv_at - 1) begin
                h1 = 12'd7; h2 = 11'd7; h3 = 10'd7; hv = 1'b1;
            end
        end
        check("ready_w4", int'(s_ready), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_ready", int'(ready), 0);
        check("rst_est", int'(est), 0);
        check("rst_est_valid", int'(ev), 0);
        check("rst_sat", int'(sat), 0);
        check("rst_drop", int'(drop), 0);
        rst_n = 1'b1;
        wait_init(10);

        upd(5, 5, 5);
        repeat (3) step();
        check("est_hold", int'(est), 1);
        upd(7, 7, 7);
        repeat (3) step();

        repeat (4) upd(100, 200, 300);
        step();
        upd(100, 200, 300);
        repeat (3) step();

        upd(9, 1, 1);
        upd(9, 2, 2);
        upd(9, 3, 3);
        upd(9, 1, 2);
        repeat (3) step();

        upd(50, 50, 50);
        step();
        upd(50, 50, 50);
        step();
        step();
        upd(50, 50, 50);
        repeat (3) step();

        upd_raw(2140, 0, 0);
        check("drop_row1_range", int'(drop), 1);
        upd_raw(0, 1070, 0);
        check("drop_row2_range", int'(drop), 1);
        upd_raw(0, 0, 535);
        check("drop_row3_range", int'(drop), 1);
        step();
        check("drop_after_range", int'(drop), 0);
        upd(2139, 1069, 534);
        repeat (3) step();

        repeat (17) upd4();
        repeat (3) step();

        upd_raw(5, 5, 5);
        upd_raw(5, 5, 5);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_ready", int'(ready), 0);
        m1.delete(); m2.delete(); m3.delete();
        wait_init(20);
        upd(5, 5, 5);
        repeat (4) step();

        check("q16_drained", q16.size(), 0);
        check("q4_drained", q4.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
